// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and frame defaults.
// Kept separate so the receiver can reuse the same constants.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_tx_state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   localparam int DEFAULT_DATA_BITS = 8;
   localparam int DEFAULT_STOP_BITS = 1;

   // Payload is zero-extended to 8 bits, so the unused upper bits do not change the XOR.
   function automatic logic parity_bit(input logic [7:0] data, input int parity);
      return (^data) ^ (parity == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: frames one word per handshake as start, LSB-first data, optional parity
// and 1-2 stop bits, advancing one bit per baud_tick strobe.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS = DEFAULT_DATA_BITS,
   parameter int PARITY    = PAR_NONE,
   parameter int STOP_BITS = DEFAULT_STOP_BITS
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 baud_tick,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx_busy,
   output logic                 txd
);

   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
      $error("uart_tx: DATA_BITS must be in 5..8");
   end
   if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
      $error("uart_tx: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end

   localparam logic [3:0] DATA_LAST = 4'(DATA_BITS);
   localparam logic [3:0] STOP_LAST = 4'(STOP_BITS);

   uart_tx_state_t       state_reg;
   logic [DATA_BITS-1:0] shift_reg;
   logic [3:0]           cnt_reg;
   logic                 parity_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= ST_IDLE;
         shift_reg  <= '0;
         cnt_reg    <= '0;
         parity_reg <= 1'b0;
         txd        <= 1'b1;
         tx_ready   <= 1'b1;
         tx_busy    <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               txd      <= 1'b1;
               tx_ready <= 1'b1;
               tx_busy  <= 1'b0;
               // tx_ready is always high here, so tx_valid alone marks acceptance.
               if (tx_valid) begin
                  shift_reg  <= tx_data;
                  parity_reg <= parity_bit(8'(tx_data), PARITY);
                  tx_ready   <= 1'b0;
                  tx_busy    <= 1'b1;
                  state_reg  <= ST_ARM;
               end
            end
            ST_ARM: begin
               // Holding the line at mark until the next tick keeps the start bit on the bit grid.
               if (baud_tick) begin
                  txd       <= 1'b0;
                  state_reg <= ST_START;
               end
            end
            ST_START: begin
               if (baud_tick) begin
                  txd       <= shift_reg[0];
                  shift_reg <= shift_reg >> 1;
                  cnt_reg   <= 4'd1;
                  state_reg <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (baud_tick) begin
                  if (cnt_reg < DATA_LAST) begin
                     txd       <= shift_reg[0];
                     shift_reg <= shift_reg >> 1;
                     cnt_reg   <= cnt_reg + 4'd1;
                  end else if (PARITY != PAR_NONE) begin
                     txd       <= parity_reg;
                     state_reg <= ST_PARITY;
                  end else begin
                     txd       <= 1'b1;
                     cnt_reg   <= 4'd1;
                     state_reg <= ST_STOP;
                  end
               end
            end
            ST_PARITY: begin
               if (baud_tick) begin
                  txd       <= 1'b1;
                  cnt_reg   <= 4'd1;
                  state_reg <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (baud_tick) begin
                  if (cnt_reg < STOP_LAST) begin
                     cnt_reg <= cnt_reg + 4'd1;
                  end else begin
                     cnt_reg   <= 4'd0;
                     tx_ready  <= 1'b1;
                     tx_busy   <= 1'b0;
                     state_reg <= ST_IDLE;
                  end
               end
            end
            default: begin
               txd       <= 1'b1;
               tx_ready  <= 1'b1;
               tx_busy   <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four frame formats side by side, scoreboard of expected bit sequences
// built at acceptance and compared by a per-channel line monitor on the baud grid.
module tb_uart_tx;

   localparam int NCH         = 4;
   localparam int TICK_PERIOD = 16;
   localparam int TIMEOUT     = 1000;

   typedef struct packed {
      logic [11:0] bits;
      logic [3:0]  len;
   } frame_t;

   function automatic int cfg_db(input int i);
      case (i)
         3:       return 7;
         default: return 8;
      endcase
   endfunction

   function automatic int cfg_par(input int i);
      case (i)
         1:       return 1;
         2:       return 2;
         3:       return 1;
         default: return 0;
      endcase
   endfunction

   function automatic int cfg_sb(input int i);
      case (i)
         3:       return 2;
         default: return 1;
      endcase
   endfunction

   // Expected line sequence from the framing rules: 0, data LSB first, parity, stop 1s.
   function automatic frame_t model(input logic [7:0] w, input int db, input int par, input int sb);
      frame_t f;
      int n = 0;
      f = '0;
      f.bits[n] = 1'b0;
      n++;
      for (int i = 0; i < db; i++) begin
         f.bits[n] = w[i];
         n++;
      end
      if (par != 0) begin
         f.bits[n] = (($countones(w) % 2) == 1) ^ (par == 2);
         n++;
      end
      for (int i = 0; i < sb; i++) begin
         f.bits[n] = 1'b1;
         n++;
      end
      f.len = 4'(n);
      return f;
   endfunction

   logic clk       = 1'b0;
   logic reset_n   = 1'b0;
   logic baud_tick = 1'b0;

   int checks        = 0;
   int errors        = 0;
   int pushed_cnt    = 0;
   int completed_cnt = 0;
   int aborted_cnt   = 0;
   int done_cnt      = 0;
   int done2_cnt     = 0;
   int tick_ctr      = 0;
   bit traffic_go    = 1'b0;
   bit phase2_go     = 1'b0;
   bit release_go    = 1'b0;

   always #5 clk = ~clk;

   task automatic check(input bit ok, input string name, input string detail);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: %s", name, detail);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         tick_ctr  = (tick_ctr + 1) % TICK_PERIOD;
         baud_tick = (tick_ctr == 0);
      end
   end

   for (genvar gi = 0; gi < NCH; gi++) begin : ch
      localparam int D = cfg_db(gi);
      localparam int P = cfg_par(gi);
      localparam int S = cfg_sb(gi);

      logic [D-1:0] tx_data;
      logic         tx_valid;
      logic         tx_ready;
      logic         tx_busy;
      logic         txd;

      uart_tx #(
         .DATA_BITS(D),
         .PARITY   (P),
         .STOP_BITS(S)
      ) dut (
         .clk      (clk),
         .reset_n  (reset_n),
         .baud_tick(baud_tick),
         .tx_data  (tx_data),
         .tx_valid (tx_valid),
         .tx_ready (tx_ready),
         .tx_busy  (tx_busy),
         .txd      (txd)
      );

      frame_t exp_q[$];
      frame_t cur;
      bit     mon_busy        = 1'b0;
      int     bit_idx         = 0;
      int     bit_cycles      = 0;
      bit     val_bad         = 1'b0;
      bit     ctl_bad         = 1'b0;
      logic   bad_val         = 1'b1;
      bit     prev_tick       = 1'b0;
      bit     acc_pending     = 1'b0;
      int     ticks_since_acc = 0;

      always @(negedge clk) begin
         if (!reset_n) begin
            aborted_cnt += exp_q.size() + (mon_busy ? 1 : 0);
            exp_q.delete();
            mon_busy    = 1'b0;
            acc_pending = 1'b0;
            prev_tick   = 1'b0;
         end else begin
            if (mon_busy) begin
               if (prev_tick) begin
                  check(!val_bad && bit_cycles == TICK_PERIOD, $sformatf("ch%0d_bit%0d", gi, bit_idx),
                        $sformatf("txd got %b over %0d cycles, want %b over %0d cycles",
                                  bad_val, bit_cycles, cur.bits[bit_idx], TICK_PERIOD));
                  bit_idx++;
                  if (bit_idx == int'(cur.len)) begin
                     mon_busy = 1'b0;
                     completed_cnt++;
                     check(!ctl_bad, $sformatf("ch%0d_ready_low_in_frame", gi),
                           "tx_ready/tx_busy left 0/1 during frame, want held 0/1");
                     check(tx_ready === 1'b1 && tx_busy === 1'b0, $sformatf("ch%0d_ready_rise", gi),
                           $sformatf("ready=%b busy=%b after last stop tick, want 1 0", tx_ready, tx_busy));
                  end else begin
                     bit_cycles = 0;
                     val_bad    = 1'b0;
                  end
               end
               if (mon_busy) begin
                  if (bit_cycles == 0) bad_val = txd;
                  bit_cycles++;
                  if (txd !== cur.bits[bit_idx]) begin
                     val_bad = 1'b1;
                     bad_val = txd;
                  end
                  if (tx_ready !== 1'b0 || tx_busy !== 1'b1) ctl_bad = 1'b1;
               end
            end else if (txd !== 1'b1) begin
               check(prev_tick && acc_pending && ticks_since_acc == 1, $sformatf("ch%0d_start_align", gi),
                     $sformatf("on_grid=%0b ticks_after_accept=%0d, want on_grid=1 ticks=1",
                               prev_tick, acc_pending ? ticks_since_acc : -1));
               if (exp_q.size() == 0) begin
                  check(1'b0, $sformatf("ch%0d_unexpected_frame", gi), "start bit with no accepted word");
                  cur     = '0;
                  cur.len = 4'd1;
               end else begin
                  cur = exp_q.pop_front();
               end
               mon_busy    = 1'b1;
               bit_idx     = 0;
               bit_cycles  = 1;
               bad_val     = txd;
               val_bad     = (txd !== cur.bits[0]);
               ctl_bad     = (tx_ready !== 1'b0 || tx_busy !== 1'b1);
               acc_pending = 1'b0;
            end
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
               exp_q.push_back(model(8'(tx_data), D, P, S));
               pushed_cnt++;
               acc_pending     = 1'b1;
               ticks_since_acc = 0;
            end else if (acc_pending && baud_tick) begin
               ticks_since_acc++;
            end
            prev_tick = baud_tick;
         end
      end

      task automatic send(input logic [7:0] w, input bit hold, input bit on_tick);
         int n = 0;
         tx_data = w[D-1:0];
         if (on_tick) begin
            while (!(tx_ready === 1'b1 && baud_tick === 1'b1) && n < TIMEOUT) begin
               @(posedge clk);
               #2;
               n++;
            end
            tx_valid = 1'b1;
         end else begin
            tx_valid = 1'b1;
            while (tx_ready !== 1'b1 && n < TIMEOUT) begin
               @(negedge clk);
               n++;
            end
         end
         if (n >= TIMEOUT) begin
            check(1'b0, $sformatf("ch%0d_accept_timeout", gi),
                  $sformatf("no acceptance within %0d cycles, want tx_ready high", TIMEOUT));
            tx_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #2;
         if (!hold) begin
            tx_valid = 1'b0;
            tx_data  = D'($urandom);
         end
      endtask

      initial begin
         tx_valid = 1'b0;
         tx_data  = '0;
         @(posedge clk);
         #3;
         check(txd === 1'b1 && tx_ready === 1'b1 && tx_busy === 1'b0, $sformatf("ch%0d_reset_state", gi),
               $sformatf("txd=%b ready=%b busy=%b, want 1 1 0", txd, tx_ready, tx_busy));
         wait (traffic_go);
         @(posedge clk);
         #2;
         case (gi)
            0: begin
               send(8'hA5, 1'b0, 1'b1);
               send(8'h55, 1'b1, 1'b0);
               send(8'hAA, 1'b0, 1'b0);
            end
            1: begin
               send(8'hA5, 1'b0, 1'b0);
               send(8'h07, 1'b0, 1'b0);
            end
            2:       send(8'hA5, 1'b0, 1'b0);
            default: send(8'h7F, 1'b0, 1'b0);
         endcase
         for (int k = 0; k < 6; k++) begin
            send(8'($urandom), (k < 5) && ($urandom_range(0, 2) == 0), 1'b0);
            if (!tx_valid) begin
               repeat ($urandom_range(0, 40)) begin
                  @(posedge clk);
                  #2;
               end
            end
         end
         done_cnt++;
         wait (phase2_go);
         @(posedge clk);
         #2;
         send(8'($urandom), 1'b0, 1'b0);
         @(negedge reset_n);
         #1;
         check(txd === 1'b1 && tx_ready === 1'b1 && tx_busy === 1'b0, $sformatf("ch%0d_reset_midframe", gi),
               $sformatf("txd=%b ready=%b busy=%b, want 1 1 0", txd, tx_ready, tx_busy));
         wait (release_go);
         @(posedge clk);
         #2;
         send(8'h3C, 1'b0, 1'b0);
         done2_cnt++;
      end
   end

   initial begin
      int n;
      repeat (4) @(posedge clk);
      #2;
      reset_n    = 1'b1;
      traffic_go = 1'b1;

      n = 0;
      while (done_cnt != NCH && n < 20000) begin
         @(posedge clk);
         n++;
      end
      check(done_cnt == NCH, "traffic_done", $sformatf("%0d channels finished, want %0d", done_cnt, NCH));
      repeat (TICK_PERIOD * 16) @(posedge clk);
      #2;
      phase2_go = 1'b1;

      n = 0;
      while (!(ch[0].mon_busy && ch[0].bit_idx == 5) && n < 2000) begin
         @(posedge clk);
         #2;
         n++;
      end
      check(ch[0].mon_busy && ch[0].bit_idx == 5, "reach_data_bit4",
            $sformatf("monitor busy=%0b bit=%0d, want busy=1 bit=5", ch[0].mon_busy, ch[0].bit_idx));
      reset_n = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      reset_n    = 1'b1;
      release_go = 1'b1;

      n = 0;
      while (done2_cnt != NCH && n < 2000) begin
         @(posedge clk);
         n++;
      end
      check(done2_cnt == NCH, "post_reset_done", $sformatf("%0d channels finished, want %0d", done2_cnt, NCH));
      repeat (TICK_PERIOD * 16) @(posedge clk);

      check(completed_cnt == 35 && aborted_cnt == 4, "frame_counts",
            $sformatf("completed=%0d aborted=%0d, want 35 and 4", completed_cnt, aborted_cnt));
      check(pushed_cnt == completed_cnt + aborted_cnt, "scoreboard_drained",
            $sformatf("pushed=%0d, want completed+aborted=%0d", pushed_cnt, completed_cnt + aborted_cnt));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      errors++;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
